// File: rtl/dmux4_sched.sv
// dmux4_sched: registered 1-to-4 demultiplexer with valid/ready handshake.
// A single producer stream is steered to one of four one-entry channel
// registers, either by the producer's in_dest field (addressed mode) or by
// a rotating search starting at rr_ptr (round-robin mode).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake (in_ready is combinational)
//   in_data [W]           producer word
//   in_dest [2]           destination channel, addressed mode only
//   mode                  0 = addressed, 1 = round-robin
//   out_valid [4]         per-channel word-present flags (registered)
//   out_ready [4]         per-channel consumer accept
//   out_data [4*W]        channel i at [i*W +: W] (registered)
//   rr_ptr [2]            round-robin start pointer (registered, status)
module dmux4_sched #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_dest,
  input  logic           mode,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic [1:0]     rr_ptr
);

  localparam int unsigned NCH = 4;

  logic [NCH-1:0] free;
  logic [1:0]     rr_tgt;
  logic           rr_hit;
  logic [1:0]     tgt;
  logic           accept;
  logic [NCH-1:0] load;

  // A channel being drained this cycle can take a new word in the same edge.
  assign free = ~out_valid | out_ready;

  // First free channel at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    rr_tgt = rr_ptr;
    rr_hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!rr_hit && free[rr_ptr + 2'(k)]) begin
        rr_tgt = rr_ptr + 2'(k);
        rr_hit = 1'b1;
      end
    end
  end

  // Target and handshake; addressed mode never searches past a blocked dest.
  always_comb begin
    tgt      = in_dest;
    in_ready = free[in_dest];
    if (mode) begin
      tgt      = rr_tgt;
      in_ready = |free;
    end
    accept = in_valid & in_ready;
    load   = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = accept & (tgt == 2'(i));
    end
  end

  // Channel registers: a load wins over a drain, giving back-to-back reuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          out_valid[i]        <= 1'b1;
          out_data[i*W +: W]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]        <= 1'b0;
        end
      end
    end
  end

  // Pointer advances past the chosen channel only on round-robin accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept && mode) begin
      rr_ptr <= tgt + 2'd1;
    end
  end

endmodule

// File: tb/tb_dmux4_sched.sv
// Directed, table-driven bench for dmux4_sched (W = 1).
module tb_dmux4_sched;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_data;
  logic [1:0] in_dest;
  logic       mode;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data;
  logic [1:0] rr_ptr;

  int n_chk  = 0;
  int n_fail = 0;

  dmux4_sched #(.W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic       valid;
    logic [1:0] dest;
    logic       data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [3:0] exp_od;
    logic [1:0] exp_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic m, logic vl, logic [1:0] d, logic dt,
                             logic [3:0] r, logic er, logic [3:0] eov,
                             logic [3:0] eod, logic [1:0] err);
    vec_t x;
    x.mode = m; x.valid = vl; x.dest = d; x.data = dt; x.ordy = r;
    x.exp_rdy = er; x.exp_ov = eov; x.exp_od = eod; x.exp_rr = err;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check in_ready, clock, check registers.
  task automatic step(int idx, vec_t x);
    mode      = x.mode;
    in_valid  = x.valid;
    in_dest   = x.dest;
    in_data   = x.data;
    out_ready = x.ordy;
    #1;
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(x.exp_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(x.exp_ov));
    chk($sformatf("v%0d out_data", idx), 32'(out_data), 32'(x.exp_od));
    chk($sformatf("v%0d rr_ptr", idx), 32'(rr_ptr), 32'(x.exp_rr));
  endtask

  initial begin
    //                 mode vld dest dat ordy    rdy ov       od       rr
    // addressed fill, then blocked dest 1 while dest 3 is free
    vecs.push_back(v(0, 1, 2'd0, 0, 4'b0000, 1, 4'b0001, 4'b0000, 2'd0));
    vecs.push_back(v(0, 1, 2'd1, 1, 4'b0000, 1, 4'b0011, 4'b0010, 2'd0));
    vecs.push_back(v(0, 1, 2'd2, 1, 4'b0000, 1, 4'b0111, 4'b0110, 2'd0));
    vecs.push_back(v(0, 1, 2'd1, 0, 4'b0000, 0, 4'b0111, 4'b0110, 2'd0));
    // round-robin fairness, all consumers ready
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 4'b0111, 2'd1));
    vecs.push_back(v(1, 1, 2'd0, 0, 4'b1111, 1, 4'b0010, 4'b0101, 2'd2));
    vecs.push_back(v(1, 1, 2'd0, 0, 4'b1111, 1, 4'b0100, 4'b0001, 2'd3));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b1000, 4'b1001, 2'd0));
    vecs.push_back(v(1, 1, 2'd0, 0, 4'b1111, 1, 4'b0001, 4'b1000, 2'd1));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0010, 4'b1010, 2'd2));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 4'b1110, 2'd3));
    vecs.push_back(v(1, 1, 2'd0, 0, 4'b1111, 1, 4'b1000, 4'b0110, 2'd0));
    // round-robin skip over full channels 1,2; then everything full
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 4'b0111, 2'd1));
    vecs.push_back(v(0, 1, 2'd1, 0, 4'b0001, 1, 4'b0010, 4'b0101, 2'd1));
    vecs.push_back(v(0, 1, 2'd2, 0, 4'b0000, 1, 4'b0110, 4'b0001, 2'd1));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b0000, 1, 4'b1110, 4'b1001, 2'd0));
    vecs.push_back(v(1, 1, 2'd0, 0, 4'b0000, 1, 4'b1111, 4'b1000, 2'd1));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b0000, 0, 4'b1111, 4'b1000, 2'd1));
    vecs.push_back(v(0, 1, 2'd3, 1, 4'b0000, 0, 4'b1111, 4'b1000, 2'd1));
    // back-to-back on channel 2, then drain all
    vecs.push_back(v(0, 1, 2'd2, 1, 4'b0100, 1, 4'b1111, 4'b1100, 2'd1));
    vecs.push_back(v(0, 1, 2'd2, 0, 4'b0100, 1, 4'b1111, 4'b1000, 2'd1));
    vecs.push_back(v(0, 0, 2'd2, 1, 4'b1111, 1, 4'b0000, 4'b1000, 2'd1));
    // mode switch every cycle under load
    vecs.push_back(v(0, 1, 2'd3, 0, 4'b1111, 1, 4'b1000, 4'b0000, 2'd1));
    vecs.push_back(v(1, 1, 2'd2, 1, 4'b1111, 1, 4'b0010, 4'b0010, 2'd2));
    vecs.push_back(v(0, 1, 2'd1, 0, 4'b1111, 1, 4'b0010, 4'b0000, 2'd2));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0100, 4'b0100, 2'd3));
    vecs.push_back(v(0, 1, 2'd3, 1, 4'b1111, 1, 4'b1000, 4'b1100, 2'd3));
    vecs.push_back(v(1, 1, 2'd2, 0, 4'b1111, 1, 4'b1000, 4'b0100, 2'd0));
    vecs.push_back(v(0, 1, 2'd1, 1, 4'b1111, 1, 4'b0010, 4'b0110, 2'd0));
    vecs.push_back(v(1, 1, 2'd0, 1, 4'b1111, 1, 4'b0001, 4'b0111, 2'd1));

    // reset state, all channels free so in_ready is high
    rst_n = 1'b0; in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd0;
    mode = 1'b0; out_ready = 4'b0000;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset rr_ptr", 32'(rr_ptr), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("reset no accept", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) step(i, vecs[i]);

    // mid-stream reset: fill a second channel, then reset between edges
    step(100, v(0, 1, 2'd2, 1, 4'b0000, 1, 4'b0101, 4'b0111, 2'd1));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst out_data", 32'(out_data), 32'h0);
    chk("midrst rr_ptr", 32'(rr_ptr), 32'h0);
    mode = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd3;
    @(posedge clk);
    #1;
    chk("midrst held", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    step(101, v(1, 1, 2'd3, 1, 4'b0000, 1, 4'b0001, 4'b0001, 2'd1));
    step(102, v(1, 1, 2'd3, 0, 4'b0000, 1, 4'b0011, 4'b0001, 2'd2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux4_sched.md
# dmux4_sched

Registered 1-to-4 demultiplexer controller that steers a W-bit input stream to four output channels under a valid/ready handshake. Each channel has a one-entry output register. The source picks the channel in one of two modes: addressed (the input's `in_dest` field) or round-robin (the block chooses). The block sits between a single producer and four independent consumers, replacing the free-running clocked demultiplexer wherever back-pressure or fair distribution is needed.

## Interface

Parameters:
- `W`, default 1: data width per channel.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low. Clears all state immediately on assertion; deassertion is synchronous to `clk`.
- `in_valid`, input, 1: producer has a word.
- `in_ready`, output, 1: block accepts the word this cycle. Combinational.
- `in_data`, input, W: input word.
- `in_dest`, input, 2: destination channel; used in addressed mode only.
- `mode`, input, 1: 0 = addressed, 1 = round-robin. Sampled every cycle.
- `out_valid`, output, 4: per-channel word-present flag. Registered.
- `out_ready`, input, 4: per-channel consumer accept.
- `out_data`, output, 4*W: channel i occupies bits [i*W +: W]. Registered.
- `rr_ptr`, output, 2: current round-robin start pointer. Registered; status only.

## Operation

- **Channel free.** `free[i] = !out_valid[i] | out_ready[i]`. A full channel being drained this cycle counts as free.
- **Target selection, addressed mode.**
  - Target is `in_dest`.
  - `in_ready = free[in_dest]`.
  - No search is done; a word for a blocked channel stalls the input even if other channels are free.
- **Target selection, round-robin mode.**
  - Search from `rr_ptr` upward, modulo 4: `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, `rr_ptr+3`.
  - Target is the first free channel found.
  - `in_ready = |free`.
  - `in_dest` is ignored.
- **Accept.** A word is accepted when `in_valid & in_ready`. On that edge:
  - `out_data[target]` loads `in_data`.
  - `out_valid[target]` is set.
- **Drain.**
  - Channel i with `out_valid[i] & out_ready[i]` and not the target this cycle: `out_valid[i]` clears.
  - If it is also the target: `out_valid[i]` stays 1 and `out_data[i]` is replaced (back-to-back, no bubble).
- **Pointer.**
  - Round-robin mode: on accept, `rr_ptr` becomes target+1 modulo 4 (3 wraps to 0).
  - Addressed mode: `rr_ptr` holds.
  - No accept: `rr_ptr` holds in both modes.
- **Data hold.**
  - `out_data[i]` changes only when channel i is the accept target.
  - When `out_valid[i]=0`, `out_data[i]` holds its last value; consumers must ignore it.
- **Mode switch.** Takes effect in the same cycle it is seen. No word is lost or duplicated; words already in channel registers are unaffected.

## Timing

- **Reset values.** `out_valid=4'b0000`, `out_data=0`, `rr_ptr=0`. `in_ready` evaluates to 1 while reset is held, because all channels are free, but no accept can occur during reset.
- **Reset mid-operation.** Buffered words are discarded immediately, without waiting for a clock edge. The first accept after release goes to channel 0 in round-robin mode.
- **Latency.** A word accepted at edge k is visible on `out_valid`/`out_data` after edge k and can be consumed at edge k+1.
- **Throughput.** One word per cycle, sustained, whenever a target channel is free.
- **Combinational paths.** `in_ready` depends combinationally on `mode`, `in_dest`, `out_valid`, `out_ready` and `rr_ptr`. No combinational path exists from `in_valid` or `in_data` to any output.
- **All channels full, none draining.** `in_ready=0`; the producer must hold `in_valid` and `in_data` until accepted.
- **Simultaneous drain and accept on one channel.** Handled as described under Operation: the output stays valid and carries the new data.

## Test plan

- **Reset and addressed fill.** Assert reset, then release. Addressed mode, `out_ready=0000`, send 0, 1, 1 to dests 0, 1, 2. Required: `out_valid=0111` with `out_data` bits 0/1/1; a further word to dest 1 sees `in_ready=0`; `rr_ptr` stays 0.
- **Round-robin fairness.** `mode=1`, `out_ready=1111`, `in_valid` held high for 8 cycles. Required: targets 0,1,2,3,0,1,2,3; `rr_ptr` sequence 1,2,3,0,1,2,3,0; no stall cycle.
- **Round-robin skip.** `mode=1`, `rr_ptr=1`, channels 1 and 2 full with `out_ready[1]=out_ready[2]=0`. Required: next word goes to channel 3 and `rr_ptr` becomes 0. With all four full and none ready: `in_ready=0` and `rr_ptr` holds.
- **Back-to-back on one channel.** Addressed mode, dest 2, `out_ready[2]=1`, data 1 then 0 on consecutive cycles. Required: `out_valid[2]` stays 1 with no bubble; `out_data[2]` shows 1 then 0.
- **Mid-stream reset.** Two channels full; assert `rst_n=0` between clock edges. Required: `out_valid=0000` and `rr_ptr=0` before the next edge; the first round-robin accept after release targets channel 0.
- **Mode switch under load.** Alternate `mode` every cycle with `in_valid=1` and `out_ready=1111`, stepping `in_dest` 3,2,1,0. Required: addressed cycles hit the given dest; round-robin cycles follow `rr_ptr`; every word appears exactly once.
